// File: rtl/timer_tick_scheduler.sv
// ============================================================================
//  Module   : timer_tick_scheduler
//  Purpose  : Avalon-MM write master that programs a 16-bit interval timer,
//             services its timeout interrupt without a CPU, and turns every
//             timeout into a one-cycle system tick. The tick drives NUM_CH
//             independent one-shot countdowns (measured in ticks).
//  Ports    : clk, reset_n           - clock, async active-low reset
//             start / stop           - pulses: program+run / halt the timer
//             base_period[31:0]      - timer period (clocks - 1), taken on start
//             arm, arm_ch, arm_ticks - load (or cancel when 0) one channel
//             tmr_*                  - Avalon-MM write master to the timer,
//                                      plus its level interrupt tmr_irq
//             running, tick          - timer active / one pulse per timeout
//             armed, expire          - per-channel active / expiry pulse
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_tick_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       base_period,
    input  logic              arm,
    input  logic [CH_W-1:0]   arm_ch,
    input  logic [TICK_W-1:0] arm_ticks,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic              tmr_irq,
    output logic              running,
    output logic              tick,
    output logic [NUM_CH-1:0] armed,
    output logic [NUM_CH-1:0] expire
);

    // Timer register map (word addresses) and control words.
    localparam logic [2:0]  C_ADDR_STATUS = 3'd0;
    localparam logic [2:0]  C_ADDR_CTRL   = 3'd1;
    localparam logic [2:0]  C_ADDR_PERL   = 3'd2;
    localparam logic [2:0]  C_ADDR_PERH   = 3'd3;
    localparam logic [15:0] C_CTRL_START  = 16'h0007; // ITO | CONT | START
    localparam logic [15:0] C_CTRL_STOP   = 16'h0008; // STOP

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_PL   = 3'd1,
        WR_PH   = 3'd2,
        WR_CTRL = 3'd3,
        RUN     = 3'd4,
        ACK     = 3'd5,
        WR_STOP = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] period_hi_q, period_hi_d;
    logic        stop_pending_q, stop_pending_d;
    logic [2:0]  addr_q, addr_d;
    logic        cs_q, cs_d;
    logic        write_n_q, write_n_d;
    logic [15:0] wdata_q, wdata_d;
    logic        running_q, running_d;
    logic        tick_q, tick_d;

    // ------------------------------------------------------------------------
    // Control FSM. Bus outputs are registered, so they are decoded from the
    // state being entered: the write belonging to a state is on the bus for
    // exactly the cycle the FSM sits in that state.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        period_hi_d    = period_hi_q;
        stop_pending_d = stop_pending_q;
        addr_d         = 3'd0;
        cs_d           = 1'b0;
        write_n_d      = 1'b1;
        wdata_d        = 16'h0000;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = WR_PL;
                    period_hi_d = base_period[31:16];
                end
            end
            WR_PL: begin
                state_d = WR_PH;
                if (stop) stop_pending_d = 1'b1;
            end
            WR_PH: begin
                state_d = WR_CTRL;
                if (stop) stop_pending_d = 1'b1;
            end
            WR_CTRL: begin
                state_d = RUN;
                if (stop) stop_pending_d = 1'b1;
            end
            RUN: begin
                if (stop || stop_pending_q) begin
                    state_d = WR_STOP;
                end else if (tmr_irq) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                // Keep a stop that arrives during the clear so it is not lost.
                state_d = RUN;
                if (stop) stop_pending_d = 1'b1;
            end
            WR_STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == WR_STOP) begin
            stop_pending_d = 1'b0;
        end

        case (state_d)
            WR_PL: begin
                // Only reachable from IDLE on start, so the live input is the
                // value being accepted this cycle.
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = C_ADDR_PERL;
                wdata_d   = base_period[15:0];
            end
            WR_PH: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = C_ADDR_PERH;
                wdata_d   = period_hi_q;
            end
            WR_CTRL: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = C_ADDR_CTRL;
                wdata_d   = C_CTRL_START;
            end
            ACK: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = C_ADDR_STATUS;
                wdata_d   = 16'h0000;
            end
            WR_STOP: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = C_ADDR_CTRL;
                wdata_d   = C_CTRL_STOP;
            end
            default: begin
                cs_d      = 1'b0;
                write_n_d = 1'b1;
            end
        endcase

        tick_d    = (state_d == ACK);
        running_d = (state_d == RUN) || (state_d == ACK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            period_hi_q    <= 16'h0000;
            stop_pending_q <= 1'b0;
            addr_q         <= 3'd0;
            cs_q           <= 1'b0;
            write_n_q      <= 1'b1;
            wdata_q        <= 16'h0000;
            running_q      <= 1'b0;
            tick_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            period_hi_q    <= period_hi_d;
            stop_pending_q <= stop_pending_d;
            addr_q         <= addr_d;
            cs_q           <= cs_d;
            write_n_q      <= write_n_d;
            wdata_q        <= wdata_d;
            running_q      <= running_d;
            tick_q         <= tick_d;
        end
    end

    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = write_n_q;
    assign tmr_writedata  = wdata_q;
    assign running        = running_q;
    assign tick           = tick_q;

    // ------------------------------------------------------------------------
    // Per-channel one-shot countdowns, advanced by the registered tick.
    // An arm in the same cycle takes precedence over the tick for that channel
    // only. Out-of-range channel indices match no channel and are ignored.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [TICK_W-1:0] cnt_q, cnt_d;
        logic              armed_q, armed_d;
        logic              expire_q, expire_d;
        logic              arm_hit;

        assign arm_hit = arm && (arm_ch == CH_W'(i));

        always_comb begin
            cnt_d    = cnt_q;
            armed_d  = armed_q;
            expire_d = 1'b0;
            if (arm_hit) begin
                if (arm_ticks != '0) begin
                    cnt_d   = arm_ticks;
                    armed_d = 1'b1;
                end else begin
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end
            end else if (tick_q && armed_q) begin
                if (cnt_q == TICK_W'(1)) begin
                    cnt_d    = '0;
                    armed_d  = 1'b0;
                    expire_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - TICK_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q    <= '0;
                armed_q  <= 1'b0;
                expire_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                armed_q  <= armed_d;
                expire_q <= expire_d;
            end
        end

        assign armed[i]  = armed_q;
        assign expire[i] = expire_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_timer_tick_scheduler.sv
// ============================================================================
//  Module   : tb_timer_tick_scheduler
//  Purpose  : Directed self-checking bench for timer_tick_scheduler. The bench
//             plays the timer's interrupt line by hand; inputs are driven and
//             outputs sampled on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_tick_scheduler;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int TICK_W = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              stop;
    logic [31:0]       base_period;
    logic              arm;
    logic [CH_W-1:0]   arm_ch;
    logic [TICK_W-1:0] arm_ticks;
    logic [2:0]        tmr_address;
    logic              tmr_chipselect;
    logic              tmr_write_n;
    logic [15:0]       tmr_writedata;
    logic              tmr_irq;
    logic              running;
    logic              tick;
    logic [NUM_CH-1:0] armed;
    logic [NUM_CH-1:0] expire;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    timer_tick_scheduler #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .TICK_W (TICK_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .stop           (stop),
        .base_period    (base_period),
        .arm            (arm),
        .arm_ch         (arm_ch),
        .arm_ticks      (arm_ticks),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq),
        .running        (running),
        .tick           (tick),
        .armed          (armed),
        .expire         (expire)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        check({tag, "_cs"},   32'(tmr_chipselect), 1);
        check({tag, "_wn"},   32'(tmr_write_n),    0);
        check({tag, "_addr"}, 32'(tmr_address),    a);
        check({tag, "_data"}, 32'(tmr_writedata),  d);
    endtask

    task automatic check_nobus(input string tag);
        check({tag, "_cs"}, 32'(tmr_chipselect), 0);
        check({tag, "_wn"}, 32'(tmr_write_n),    1);
    endtask

    task automatic check_rst(input string tag);
        check_nobus(tag);
        check({tag, "_addr"},    32'(tmr_address),   0);
        check({tag, "_data"},    32'(tmr_writedata), 0);
        check({tag, "_running"}, 32'(running),       0);
        check({tag, "_tick"},    32'(tick),          0);
        check({tag, "_armed"},   32'(armed),         0);
        check({tag, "_expire"},  32'(expire),        0);
    endtask

    task automatic do_arm(input logic [CH_W-1:0] ch, input logic [TICK_W-1:0] t);
        arm = 1'b1; arm_ch = ch; arm_ticks = t;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // One serviced timeout from RUN; optional arm on the tick cycle.
    task automatic do_tick(input string tag, input logic [NUM_CH-1:0] exp_exp,
                           input logic a, input logic [CH_W-1:0] ach,
                           input logic [TICK_W-1:0] at);
        tmr_irq = 1'b1;
        @(negedge clk);
        check_wr({tag, "_ack"}, 0, 0);
        check({tag, "_tick"}, 32'(tick), 1);
        tmr_irq = 1'b0;
        arm = a; arm_ch = ach; arm_ticks = at;
        @(negedge clk);
        arm = 1'b0;
        check({tag, "_tick_off"}, 32'(tick), 0);
        check_nobus({tag, "_after"});
        check({tag, "_expire"}, 32'(expire), 32'(exp_exp));
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; arm = 1'b0;
        arm_ch = '0; arm_ticks = '0; tmr_irq = 1'b0; base_period = '0;
        repeat (3) @(negedge clk);
        check_rst("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Initial programming sequence.
        base_period = 32'h0001_86A0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; base_period = '0;
        check_wr("wr_pl", 2, 'h86A0);
        @(negedge clk);
        check_wr("wr_ph", 3, 'h0001);
        check("run_in_ph", 32'(running), 0);
        @(negedge clk);
        check_wr("wr_ctrl", 1, 'h0007);
        check("run_in_ctrl", 32'(running), 0);
        @(negedge clk);
        check("run_on", 32'(running), 1);
        check_nobus("run_idle");

        // Single serviced timeout.
        do_tick("t0", 4'b0000, 1'b0, 2'd0, 16'd0);

        // ch2 with 3 ticks.
        do_arm(2'd2, 16'd3);
        check("armed_ch2", 32'(armed), 'b0100);
        do_tick("c2a", 4'b0000, 1'b0, 2'd0, 16'd0);
        do_tick("c2b", 4'b0000, 1'b0, 2'd0, 16'd0);
        check("armed_ch2_still", 32'(armed), 'b0100);
        do_tick("c2c", 4'b0100, 1'b0, 2'd0, 16'd0);
        check("armed_ch2_clr", 32'(armed), 0);
        @(negedge clk);
        check("expire_one_cycle", 32'(expire), 0);

        // Re-arm ch1 on the cycle it would expire: arm wins.
        do_arm(2'd1, 16'd1);
        check("armed_ch1", 32'(armed), 'b0010);
        do_tick("c1re", 4'b0000, 1'b1, 2'd1, 16'd5);
        check("armed_ch1_re", 32'(armed), 'b0010);
        for (int k = 0; k < 4; k++) begin
            do_tick("c1w", 4'b0000, 1'b0, 2'd0, 16'd0);
        end
        do_tick("c1x", 4'b0010, 1'b0, 2'd0, 16'd0);
        check("armed_ch1_clr", 32'(armed), 0);

        // Cancel ch0 on its final tick while ch3 expires normally.
        do_arm(2'd3, 16'd2);
        do_arm(2'd0, 16'd2);
        check("armed_ch03", 32'(armed), 'b1001);
        do_tick("c03a", 4'b0000, 1'b0, 2'd0, 16'd0);
        do_tick("c03b", 4'b1000, 1'b1, 2'd0, 16'd0);
        check("armed_ch03_clr", 32'(armed), 0);

        // Arm ch2 then stop from RUN; the countdown must hold while stopped.
        do_arm(2'd2, 16'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_wr("wr_stop", 1, 'h0008);
        check("run_in_stop", 32'(running), 0);
        @(negedge clk);
        check_nobus("idle_a");
        check("run_idle_a", 32'(running), 0);

        // Stop during WR_PH, with irq pending as RUN is entered.
        base_period = 32'h0000_0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_wr("sp_pl", 2, 'h0010);
        @(negedge clk);
        check_wr("sp_ph", 3, 'h0000);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_wr("sp_ctrl", 1, 'h0007);
        tmr_irq = 1'b1;
        @(negedge clk);
        check("sp_run", 32'(running), 1);
        check_nobus("sp_run_bus");
        @(negedge clk);
        check_wr("sp_stop", 1, 'h0008);
        check("sp_run_off", 32'(running), 0);
        check("sp_no_tick", 32'(tick), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_nobus("idle_irq");
            check("idle_irq_tick", 32'(tick), 0);
            check("idle_irq_exp", 32'(expire), 0);
        end
        tmr_irq = 1'b0;
        check("armed_paused", 32'(armed), 'b0100);

        // Restart: ch2 resumes and expires on the first tick.
        base_period = 32'h0000_0020; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_wr("rs_pl", 2, 'h0020);
        repeat (3) @(negedge clk);
        check("rs_run", 32'(running), 1);
        do_tick("rs_t", 4'b0100, 1'b0, 2'd0, 16'd0);
        check("rs_armed_clr", 32'(armed), 0);

        // Reset in the middle of the WR_PL write.
        do_arm(2'd3, 16'd9);
        check("armed_ch3", 32'(armed), 'b1000);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        base_period = 32'h0000_1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_wr("mr_pl", 2, 'h1234);
        #2 reset_n = 1'b0;
        #1 check_rst("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_rst("post_reset");

        base_period = 32'h5678_9ABC; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_wr("r2_pl", 2, 'h9ABC);
        @(negedge clk);
        check_wr("r2_ph", 3, 'h5678);
        @(negedge clk);
        check_wr("r2_ctrl", 1, 'h0007);
        @(negedge clk);
        check("r2_run", 32'(running), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
